// File: rtl/sht30_pkg.sv
// Shared constants, FSM encoding and helpers for the SHT30 setpoint-to-raw-code converter.
// Limits are in tenths of a unit, which matches the accumulated BCD value.
package sht30_pkg;

  localparam logic [10:0] T_OFFSET    = 11'd450;
  localparam logic [10:0] T_DIVISOR   = 11'd1750;
  localparam logic [10:0] H_DIVISOR   = 11'd1000;
  localparam logic [13:0] T_POS_MAX   = 14'd1300;
  localparam logic [13:0] T_NEG_MAX   = 14'd450;
  localparam logic [13:0] H_MAX       = 14'd1000;
  localparam logic [3:0]  MINUS_DIGIT = 4'hA;
  localparam logic [15:0] CODE_CLAMP  = 16'hFFFF;

  localparam int NUM_W = 27;
  localparam int DEN_W = 11;
  localparam int QUO_W = 17;
  localparam logic [4:0] DIV_STEPS = 5'd27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_T,
    ST_RANGE_T,
    ST_DIV_T,
    ST_LOAD_H,
    ST_RANGE_H,
    ST_DIV_H,
    ST_DONE
  } state_t;

  // A quotient of exactly 65536 (full-scale setpoint) does not fit in 16 bits.
  function automatic logic [15:0] clamp_code(input logic [QUO_W-1:0] q);
    return q[QUO_W-1] ? CODE_CLAMP : q[15:0];
  endfunction

endpackage

// File: rtl/seq_div.sv
// Restoring divider, one quotient bit per cycle. The first step is taken on the start
// edge itself, so done is high in the 27th cycle after start and the quotient holds afterwards.
module seq_div
  import sht30_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NUM_W-1:0] numer,
  input  logic [DEN_W-1:0] denom,
  output logic             done,
  output logic [QUO_W-1:0] quot
);

  logic [DEN_W-1:0] rem_q, rem_d;
  logic [DEN_W-1:0] den_q, den_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [QUO_W-1:0] quot_q, quot_d;
  logic [4:0]       cnt_q, cnt_d;
  logic             run_q, run_d;

  logic [DEN_W-1:0] rem_src;
  logic [DEN_W-1:0] den_src;
  logic             in_bit;
  logic [DEN_W:0]   trial;
  logic             q_bit;
  logic [DEN_W-1:0] step_rem;

  always_comb begin
    rem_src = start ? '0 : rem_q;
    den_src = start ? denom : den_q;
    in_bit  = start ? numer[NUM_W-1] : num_q[NUM_W-1];
    trial   = {rem_src, in_bit};
    q_bit   = (trial >= {1'b0, den_src});
    // The remainder after a successful subtract is below the divisor, so the low bits suffice.
    step_rem = q_bit ? (trial[DEN_W-1:0] - den_src) : trial[DEN_W-1:0];

    rem_d  = rem_q;
    den_d  = den_q;
    num_d  = num_q;
    quot_d = quot_q;
    cnt_d  = cnt_q;
    run_d  = run_q;

    if (start) begin
      rem_d  = step_rem;
      den_d  = denom;
      num_d  = {numer[NUM_W-2:0], 1'b0};
      quot_d = {{(QUO_W-1){1'b0}}, q_bit};
      cnt_d  = DIV_STEPS - 5'd1;
      run_d  = 1'b1;
    end else if (run_q) begin
      if (cnt_q == 5'd0) begin
        run_d = 1'b0;
      end else begin
        rem_d  = step_rem;
        num_d  = {num_q[NUM_W-2:0], 1'b0};
        quot_d = {quot_q[QUO_W-2:0], q_bit};
        cnt_d  = cnt_q - 5'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      den_q  <= '0;
      num_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      den_q  <= den_d;
      num_q  <= num_d;
      quot_q <= quot_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
    end
  end

  assign done = run_q && (cnt_q == 5'd0);
  assign quot = quot_q;

endmodule

// File: rtl/set_to_code.sv
// Converts BCD temperature/humidity setpoints into SHT30 raw alert codes using one shared
// divider; fixed 65-cycle latency from start-accept to the done pulse.
module set_to_code
  import sht30_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] T_set,
  input  logic [15:0] H_set,
  output logic        busy,
  output logic        done,
  output logic [15:0] T_code,
  output logic [15:0] H_code,
  output logic        T_err,
  output logic        H_err
);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [13:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic        err_q, err_d;
  logic [15:0] t_set_q, t_set_d;
  logic [15:0] h_set_q, h_set_d;
  logic [15:0] t_hold_q, t_hold_d;
  logic        t_hold_err_q, t_hold_err_d;
  logic [15:0] t_code_q, t_code_d;
  logic [15:0] h_code_q, h_code_d;
  logic        t_err_q, t_err_d;
  logic        h_err_q, h_err_d;

  logic             load_t;
  logic             lead_t;
  logic [15:0]      cur_set;
  logic [3:0]       raw_digit;
  logic [3:0]       digit_val;
  logic             digit_bad;
  logic [10:0]      off_t;
  logic             t_bad;
  logic             h_bad;
  logic             div_start;
  logic [NUM_W-1:0] div_numer;
  logic [DEN_W-1:0] div_denom;
  logic             div_done;
  logic [QUO_W-1:0] div_quot;

  // Digit presented to the Horner accumulator this cycle, MSD first.
  always_comb begin
    load_t  = (state_q == ST_LOAD_T);
    lead_t  = load_t && (cnt_q == 2'd0);
    cur_set = load_t ? t_set_q : h_set_q;
    case (cnt_q)
      2'd0:    raw_digit = cur_set[15:12];
      2'd1:    raw_digit = cur_set[11:8];
      2'd2:    raw_digit = cur_set[7:4];
      default: raw_digit = cur_set[3:0];
    endcase
    if (lead_t) begin
      digit_bad = !((raw_digit == 4'd0) || (raw_digit == 4'd1) || (raw_digit == MINUS_DIGIT));
      digit_val = (raw_digit == MINUS_DIGIT) ? 4'd0 : raw_digit;
    end else begin
      digit_bad = (raw_digit > 4'd9);
      digit_val = raw_digit;
    end
    off_t = neg_q ? (T_OFFSET - acc_q[10:0]) : (T_OFFSET + acc_q[10:0]);
    t_bad = err_q || (neg_q ? (acc_q > T_NEG_MAX) : (acc_q > T_POS_MAX));
    h_bad = err_q || (acc_q > H_MAX);
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    neg_d        = neg_q;
    err_d        = err_q;
    t_set_d      = t_set_q;
    h_set_d      = h_set_q;
    t_hold_d     = t_hold_q;
    t_hold_err_d = t_hold_err_q;
    t_code_d     = t_code_q;
    h_code_d     = h_code_q;
    t_err_d      = t_err_q;
    h_err_d      = h_err_q;
    div_start    = 1'b0;
    div_numer    = '0;
    div_denom    = T_DIVISOR;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_T;
          t_set_d = T_set;
          h_set_d = H_set;
          cnt_d   = 2'd0;
          acc_d   = '0;
          neg_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_LOAD_T, ST_LOAD_H: begin
        acc_d = acc_q * 14'd10 + {10'd0, digit_val};
        err_d = err_q || digit_bad;
        if (lead_t) neg_d = (raw_digit == MINUS_DIGIT);
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = load_t ? ST_RANGE_T : ST_RANGE_H;
      end
      ST_RANGE_T: begin
        // Invalid channels still run the divider on zero so the latency never changes.
        err_d     = t_bad;
        div_start = 1'b1;
        div_numer = t_bad ? '0 : {off_t, 16'd0};
        div_denom = T_DIVISOR;
        state_d   = ST_DIV_T;
      end
      ST_DIV_T: begin
        if (div_done) begin
          t_hold_d     = err_q ? 16'd0 : clamp_code(div_quot);
          t_hold_err_d = err_q;
          state_d      = ST_LOAD_H;
          cnt_d        = 2'd0;
          acc_d        = '0;
          neg_d        = 1'b0;
          err_d        = 1'b0;
        end
      end
      ST_RANGE_H: begin
        err_d     = h_bad;
        div_start = 1'b1;
        div_numer = h_bad ? '0 : {acc_q[10:0], 16'd0};
        div_denom = H_DIVISOR;
        state_d   = ST_DIV_H;
      end
      ST_DIV_H: begin
        if (div_done) begin
          t_code_d = t_hold_q;
          t_err_d  = t_hold_err_q;
          h_code_d = err_q ? 16'd0 : clamp_code(div_quot);
          h_err_d  = err_q;
          state_d  = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      neg_q        <= 1'b0;
      err_q        <= 1'b0;
      t_set_q      <= '0;
      h_set_q      <= '0;
      t_hold_q     <= '0;
      t_hold_err_q <= 1'b0;
      t_code_q     <= '0;
      h_code_q     <= '0;
      t_err_q      <= 1'b0;
      h_err_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      neg_q        <= neg_d;
      err_q        <= err_d;
      t_set_q      <= t_set_d;
      h_set_q      <= h_set_d;
      t_hold_q     <= t_hold_d;
      t_hold_err_q <= t_hold_err_d;
      t_code_q     <= t_code_d;
      h_code_q     <= h_code_d;
      t_err_q      <= t_err_d;
      h_err_q      <= h_err_d;
    end
  end

  seq_div u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .numer (div_numer),
    .denom (div_denom),
    .done  (div_done),
    .quot  (div_quot)
  );

  assign busy   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done   = (state_q == ST_DONE);
  assign T_code = t_code_q;
  assign H_code = h_code_q;
  assign T_err  = t_err_q;
  assign H_err  = h_err_q;

endmodule

// File: tb/tb_set_to_code.sv
// Bench for set_to_code: directed vector table, randomized setpoints against a decimal
// reference model, and hand-written reset/start-timing sequences.
module tb_set_to_code;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [15:0] T_set = '0;
  logic [15:0] H_set = '0;
  logic        busy, done, T_err, H_err;
  logic [15:0] T_code, H_code;

  int checkCount = 0;
  int passCount  = 0;

  set_to_code dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .T_set  (T_set),
    .H_set  (H_set),
    .busy   (busy),
    .done   (done),
    .T_code (T_code),
    .H_code (H_code),
    .T_err  (T_err),
    .H_err  (H_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] tSet;
    logic [15:0] hSet;
    logic [15:0] tCode;
    logic [15:0] hCode;
    logic        tErr;
    logic        hErr;
  } vec_t;

  vec_t vecs [10];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic int digitAt(input logic [15:0] v, input int pos);
    return int'(v[pos*4 +: 4]);
  endfunction

  // Reference: decode decimal setpoint, apply limits, scale with 64-bit integer arithmetic.
  function automatic void refTemp(input logic [15:0] s, output int code, output int err);
    int     hund, tens, units, tenths, mag, off;
    bit     neg;
    longint q;
    hund   = digitAt(s, 3);
    tens   = digitAt(s, 2);
    units  = digitAt(s, 1);
    tenths = digitAt(s, 0);
    neg    = (hund == 10);
    mag    = (neg ? 0 : hund) * 1000 + tens * 100 + units * 10 + tenths;
    err    = 0;
    if (tens > 9 || units > 9 || tenths > 9) err = 1;
    if (!(hund == 0 || hund == 1 || neg)) err = 1;
    if (!neg && mag > 1300) err = 1;
    if (neg && mag > 450) err = 1;
    code = 0;
    if (err == 0) begin
      off  = neg ? 450 - mag : 450 + mag;
      q    = (longint'(off) * 65536) / 1750;
      code = (q > 65535) ? 65535 : int'(q);
    end
  endfunction

  function automatic void refHum(input logic [15:0] s, output int code, output int err);
    int     mag;
    longint q;
    err = 0;
    for (int i = 0; i < 4; i++) if (digitAt(s, i) > 9) err = 1;
    mag = digitAt(s, 3) * 1000 + digitAt(s, 2) * 100 + digitAt(s, 1) * 10 + digitAt(s, 0);
    if (mag > 1000) err = 1;
    code = 0;
    if (err == 0) begin
      q    = (longint'(mag) * 65536) / 1000;
      code = (q > 65535) ? 65535 : int'(q);
    end
  endfunction

  function automatic logic [15:0] encodeTenths(input int t);
    int m;
    if (t < 0) begin
      m = -t;
      return {4'hA, 4'(m / 100 % 10), 4'(m / 10 % 10), 4'(m % 10)};
    end
    return {4'(t / 1000 % 10), 4'(t / 100 % 10), 4'(t / 10 % 10), 4'(t % 10)};
  endfunction

  // Starts one conversion, scrambles the inputs after the accept edge, waits for done.
  task automatic runConversion(input logic [15:0] tS, input logic [15:0] hS, output int lat);
    @(negedge clk);
    T_set = tS;
    H_set = hS;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    T_set = 16'($urandom);
    H_set = 16'($urandom);
    lat = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (c == 1 || c == 64) checkOutput("busy_during_conv", int'(busy), 1);
      if (done) begin
        lat = c;
        break;
      end
    end
    @(negedge clk);
    checkOutput("done_one_cycle", int'(done), 0);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    int lat;
    runConversion(v.tSet, v.hSet, lat);
    checkOutput({tag, "_latency"}, lat, 65);
    checkOutput({tag, "_T_code"}, int'(T_code), int'(v.tCode));
    checkOutput({tag, "_H_code"}, int'(H_code), int'(v.hCode));
    checkOutput({tag, "_T_err"}, int'(T_err), int'(v.tErr));
    checkOutput({tag, "_H_err"}, int'(H_err), int'(v.hErr));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   tc, te, hc, he;
    int   cnt, d1, d2;
    vec_t v;

    vecs[0] = '{16'h0250, 16'h0500, 16'h6666, 16'h8000, 1'b0, 1'b0};
    vecs[1] = '{16'hA105, 16'h0000, 16'd12919, 16'd0,  1'b0, 1'b0};
    vecs[2] = '{16'h1300, 16'h1000, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0};
    vecs[3] = '{16'hA450, 16'h0999, 16'd0,    16'd65470, 1'b0, 1'b0};
    vecs[4] = '{16'h02B0, 16'h1001, 16'd0,    16'd0,   1'b1, 1'b1};
    vecs[5] = '{16'h0000, 16'h0001, 16'd16852, 16'd65, 1'b0, 1'b0};
    vecs[6] = '{16'h1301, 16'h0000, 16'd0,    16'd0,   1'b1, 1'b0};
    vecs[7] = '{16'hA451, 16'h2000, 16'd0,    16'd0,   1'b1, 1'b1};
    vecs[8] = '{16'h2000, 16'h0A00, 16'd0,    16'd0,   1'b1, 1'b1};
    vecs[9] = '{16'h0999, 16'h0123, 16'd54263, 16'd8060, 1'b0, 1'b0};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_T_code", int'(T_code), 0);
    checkOutput("reset_H_code", int'(H_code), 0);
    checkOutput("reset_T_err", int'(T_err), 0);
    checkOutput("reset_H_err", int'(H_err), 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 25; i++) begin
      if ($urandom_range(9, 0) == 0) v.tSet = 16'($urandom);
      else v.tSet = encodeTenths(int'($urandom_range(1900, 0)) - 520);
      if ($urandom_range(9, 0) == 0) v.hSet = 16'($urandom);
      else v.hSet = encodeTenths(int'($urandom_range(1050, 0)));
      refTemp(v.tSet, tc, te);
      refHum(v.hSet, hc, he);
      v.tCode = 16'(tc);
      v.hCode = 16'(hc);
      v.tErr  = (te != 0);
      v.hErr  = (he != 0);
      applyStimulus(v, $sformatf("rand%0d", i));
    end

    // Abort with reset in cycle 20 after outputs hold non-zero values.
    applyStimulus(vecs[0], "pre_abort");
    @(negedge clk);
    T_set = 16'h0250;
    H_set = 16'h0500;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_T_code", int'(T_code), 0);
    checkOutput("abort_H_code", int'(H_code), 0);
    checkOutput("abort_T_err", int'(T_err), 0);
    checkOutput("abort_H_err", int'(H_err), 0);
    cnt = 0;
    repeat (100) begin
      @(negedge clk);
      if (done) cnt++;
    end
    checkOutput("abort_no_done", cnt, 0);
    applyStimulus(vecs[1], "after_abort");

    // A start pulse in cycle 10 of a conversion is dropped.
    @(negedge clk);
    T_set = 16'h0999;
    H_set = 16'h0123;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    cnt = 0;
    d1  = -1;
    for (int c = 1; c <= 150; c++) begin
      @(negedge clk);
      if (c == 10) start = 1'b1;
      if (c == 11) start = 1'b0;
      if (done) begin
        cnt++;
        if (d1 < 0) d1 = c;
      end
    end
    checkOutput("busy_start_done_count", cnt, 1);
    checkOutput("busy_start_done_cycle", d1, 65);
    checkOutput("busy_start_T_code", int'(T_code), 54263);

    // start held high: ignored in DONE, re-accepted in the following IDLE cycle.
    @(negedge clk);
    T_set = 16'h0000;
    H_set = 16'h0001;
    start = 1'b1;
    @(posedge clk);
    d1 = -1;
    d2 = -1;
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) d1 = c;
        else begin
          d2 = c;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    checkOutput("held_first_done", d1, 65);
    checkOutput("held_second_done", d2, 131);
    checkOutput("held_T_code", int'(T_code), 16852);
    checkOutput("held_H_code", int'(H_code), 65);
    repeat (3) @(negedge clk);
    checkOutput("held_idle_after", int'(busy), 0);

    // Reset wins over a simultaneous start.
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkOutput("rst_prio_busy", int'(busy), 0);
    checkOutput("rst_prio_T_code", int'(T_code), 0);
    repeat (5) @(negedge clk);
    checkOutput("rst_prio_busy_later", int'(busy), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
